// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - time-multiplexed seven-segment driver with tear-free loading
// Pending inputs are promoted to the active set only at the frame boundary.
module sseg_scan_mux #(
  parameter int NUM_DIGITS = 3,
  parameter int DWELL_BITS = 16,
  parameter int BLINK_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_start
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DWELL_BITS-1:0]   dwell_q, dwell_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLINK_BITS-1:0]   blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [5*NUM_DIGITS-1:0] act_hex_q, act_hex_d, pend_hex_q, pend_hex_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d, pend_blink_q, pend_blink_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              sseg_q, sseg_d;
  logic                    fs_q, fs_d;

  logic                    dwell_wrap, frame_end;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [4:0]              cur_code;
  logic                    suppressed, lit;

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'h00:   return 7'b0000001;
      5'h01:   return 7'b1001111;
      5'h02:   return 7'b0010010;
      5'h03:   return 7'b0000110;
      5'h04:   return 7'b1001100;
      5'h05:   return 7'b0100100;
      5'h06:   return 7'b0100000;
      5'h07:   return 7'b0001111;
      5'h08:   return 7'b0000000;
      5'h09:   return 7'b0000100;
      5'h0A:   return 7'b0001000;
      5'h0B:   return 7'b1100000;
      5'h0C:   return 7'b0110001;
      5'h0D:   return 7'b1000010;
      5'h0E:   return 7'b0110000;
      5'h0F:   return 7'b0111000;
      5'h10:   return 7'b1000001;
      5'h12:   return 7'b1111111;
      default: return 7'b1111110;
    endcase
  endfunction

  assign dwell_wrap = &dwell_q;
  assign frame_end  = dwell_wrap && (idx_q == LAST_IDX);

  always_comb begin
    dwell_d       = dwell_q + 1'b1;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (dwell_wrap) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    if (frame_end) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (&blink_cnt_q) blink_phase_d = ~blink_phase_q;
    end
  end

  // A load landing on the boundary edge bypasses pending and goes straight to active.
  always_comb begin
    act_hex_d    = act_hex_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    act_blink_d  = act_blink_q;
    pend_hex_d   = pend_hex_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_blink_d = pend_blink_q;
    pend_flag_d  = pend_flag_q;
    if (load) begin
      pend_hex_d   = hex_in;
      pend_dp_d    = dp_in;
      pend_en_d    = en_in;
      pend_blink_d = blink_in;
      pend_flag_d  = 1'b1;
    end
    if (frame_end) begin
      pend_flag_d = 1'b0;
      if (load) begin
        act_hex_d   = hex_in;
        act_dp_d    = dp_in;
        act_en_d    = en_in;
        act_blink_d = blink_in;
      end else if (pend_flag_q) begin
        act_hex_d   = pend_hex_q;
        act_dp_d    = pend_dp_q;
        act_en_d    = pend_en_q;
        act_blink_d = pend_blink_q;
      end
    end
  end

  // lz_zero[k] is set when digit k and every digit above it hold code 0.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_zero  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero   = all_zero && (act_hex_q[5*k +: 5] == 5'd0);
      lz_zero[k] = all_zero;
    end
  end

  assign cur_code   = act_hex_q[5*int'(idx_q) +: 5];
  assign suppressed = lz_suppress && (idx_q != '0) && lz_zero[idx_q];
  assign lit        = act_en_q[idx_q] && !(act_blink_q[idx_q] && blink_phase_q) && !suppressed
                      && (dwell_q[DWELL_BITS-1 -: 4] <= brightness);

  always_comb begin
    an_d   = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    sseg_d = lit ? {~act_dp_q[idx_q], glyph(cur_code)} : 8'hFF;
    fs_d   = (idx_q == '0) && (dwell_q == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q       <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      act_hex_q     <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      act_blink_q   <= '0;
      pend_hex_q    <= '0;
      pend_dp_q     <= '0;
      pend_en_q     <= '0;
      pend_blink_q  <= '0;
      pend_flag_q   <= 1'b0;
      an_q          <= '1;
      sseg_q        <= 8'hFF;
      fs_q          <= 1'b0;
    end else begin
      dwell_q       <= dwell_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      act_hex_q     <= act_hex_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      act_blink_q   <= act_blink_d;
      pend_hex_q    <= pend_hex_d;
      pend_dp_q     <= pend_dp_d;
      pend_en_q     <= pend_en_d;
      pend_blink_q  <= pend_blink_d;
      pend_flag_q   <= pend_flag_d;
      an_q          <= an_d;
      sseg_q        <= sseg_d;
      fs_q          <= fs_d;
    end
  end

  assign an          = an_q;
  assign sseg        = sseg_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - scoreboard bench for sseg_scan_mux
// Four digits, 16-clock dwell, blink phase toggling every two frames.
module tb_sseg_scan_mux;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] hex_in = '0;
  logic [3:0]  dp_in = '0, en_in = '0, blink_in = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = '0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;

  int tests = 0;
  int failures = 0;
  int edges = 0;
  logic [12:0] exp_q[$];

  logic [19:0] m_hex, p_hex;
  logic [3:0]  m_dp, m_en, m_blink, p_dp, p_en, p_blink;
  logic        p_flag;

  always #5 clk = ~clk;

  sseg_scan_mux #(.NUM_DIGITS(4), .DWELL_BITS(4), .BLINK_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .en_in(en_in), .blink_in(blink_in), .lz_suppress(lz_suppress),
    .brightness(brightness), .an(an), .sseg(sseg), .frame_start(frame_start)
  );

  function automatic logic [6:0] glyph_ref(input logic [4:0] c);
    case (c)
      5'h00: return 7'b0000001;  5'h01: return 7'b1001111;
      5'h02: return 7'b0010010;  5'h03: return 7'b0000110;
      5'h04: return 7'b1001100;  5'h05: return 7'b0100100;
      5'h06: return 7'b0100000;  5'h07: return 7'b0001111;
      5'h08: return 7'b0000000;  5'h09: return 7'b0000100;
      5'h0A: return 7'b0001000;  5'h0B: return 7'b1100000;
      5'h0C: return 7'b0110001;  5'h0D: return 7'b1000010;
      5'h0E: return 7'b0110000;  5'h0F: return 7'b0111000;
      5'h10: return 7'b1000001;  5'h12: return 7'b1111111;
      default: return 7'b1111110;
    endcase
  endfunction

  // Expected {frame_start, an, sseg} one clock after the counters sit at count s.
  function automatic logic [12:0] expect_out(input int s);
    int dw, ix;
    logic ph, lit, allz;
    logic [3:0] an_e;
    logic [7:0] ss_e;
    dw = s % 16;
    ix = (s / 16) % 4;
    ph = (((s / 64) / 2) % 2) == 1;
    lit = m_en[ix] && !(m_blink[ix] && ph) && (dw <= int'(brightness));
    allz = 1'b1;
    for (int j = ix; j < 4; j++) if (m_hex[5*j +: 5] != 5'd0) allz = 1'b0;
    if (lz_suppress && ix > 0 && allz) lit = 1'b0;
    an_e = lit ? ~(4'b0001 << ix) : 4'hF;
    ss_e = lit ? {~m_dp[ix], glyph_ref(m_hex[5*ix +: 5])} : 8'hFF;
    return {((s % 64) == 0), an_e, ss_e};
  endfunction

  task automatic reset_model();
    edges = 0;
    m_hex = '0; m_dp = '0; m_en = '0; m_blink = '0;
    p_hex = '0; p_dp = '0; p_en = '0; p_blink = '0; p_flag = 1'b0;
  endtask

  task automatic tick();
    logic ld;
    ld = load;
    @(posedge clk);
    edges++;
    if (ld && edges % 64 == 0) begin
      m_hex = hex_in; m_dp = dp_in; m_en = en_in; m_blink = blink_in; p_flag = 1'b0;
    end else if (ld) begin
      p_hex = hex_in; p_dp = dp_in; p_en = en_in; p_blink = blink_in; p_flag = 1'b1;
    end else if (edges % 64 == 0 && p_flag) begin
      m_hex = p_hex; m_dp = p_dp; m_en = p_en; m_blink = p_blink; p_flag = 1'b0;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] want;
    repeat (3) begin
      exp_q.push_back({1'b0, 4'hF, 8'hFF});
      @(negedge clk);
      want = exp_q.pop_front();
      tests++;
      if ({frame_start, an, sseg} !== want) begin
        failures++;
        $display("FAIL reset got fs/an/sseg=%b/%h/%h want %b/%h/%h", frame_start, an, sseg, want[12], want[11:8], want[7:0]);
      end
    end
    reset_n = 1'b1;
    reset_model();
  endtask

  task automatic test_scan_order();
    logic [12:0] want;
    int last_fs;
    last_fs = -1;
    brightness = 4'd15; hex_in = {5'd3, 5'd2, 5'd1, 5'd0}; en_in = 4'hF; dp_in = '0; load = 1'b1;
    repeat (192) begin
      exp_q.push_back(expect_out(edges));
      tick();
      want = exp_q.pop_front();
      tests++;
      if ({frame_start, an, sseg} !== want) begin
        failures++;
        $display("FAIL scan e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
      end
      if (frame_start) begin
        if (last_fs >= 0) begin
          tests++;
          if (edges - last_fs != 64) begin
            failures++;
            $display("FAIL fs_period got %0d want 64", edges - last_fs);
          end
        end
        last_fs = edges;
      end
      if (edges >= 65 && edges <= 113 && (edges - 65) % 16 == 0) begin
        tests++;
        if (an !== ~(4'b0001 << ((edges - 65) / 16))) begin
          failures++;
          $display("FAIL scan_step e=%0d got an=%h want %h", edges, an, ~(4'b0001 << ((edges - 65) / 16)));
        end
      end
    end
  endtask

  task automatic test_tear_free();
    logic [12:0] want;
    int phase;
    for (phase = 0; phase < 3; phase++) begin
      if (phase == 1) begin
        hex_in = {5'h0D, 5'h0C, 5'h0B, 5'h0A}; dp_in = 4'b0101; load = 1'b1;
      end else if (phase == 2) begin
        hex_in = {5'h13, 5'h12, 5'h11, 5'h10}; load = 1'b1;
      end
      do begin
        exp_q.push_back(expect_out(edges));
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({frame_start, an, sseg} !== want) begin
          failures++;
          $display("FAIL tear e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
        end
        if (phase > 0 && edges % 64 == 1) begin
          tests++;
          if ({frame_start, sseg} !== {1'b1, 1'b0, glyph_ref(phase == 1 ? 5'h0A : 5'h10)}) begin
            failures++;
            $display("FAIL tear_update p=%0d got fs/sseg=%b/%h", phase, frame_start, sseg);
          end
        end
      end while (edges % 64 != (phase == 0 ? 20 : (phase == 1 ? 63 : 0)));
    end
  endtask

  task automatic test_brightness();
    logic [12:0] want;
    int cnt[4];
    logic [3:0] levels[3];
    levels = '{4'd0, 4'd7, 4'd15};
    hex_in = {4{5'h08}}; en_in = 4'hF; dp_in = '0; load = 1'b1;
    foreach (levels[li]) begin
      if (li > 0) brightness = levels[li];
      else brightness = 4'd15;
      for (int d = 0; d < 4; d++) cnt[d] = 0;
      do begin
        exp_q.push_back(expect_out(edges));
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({frame_start, an, sseg} !== want) begin
          failures++;
          $display("FAIL bright e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
        end
      end while (edges % 64 != 0);
      brightness = levels[li];
      repeat (64) begin
        exp_q.push_back(expect_out(edges));
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({frame_start, an, sseg} !== want) begin
          failures++;
          $display("FAIL bright e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
        end
        for (int d = 0; d < 4; d++) if (an === ~(4'b0001 << d)) cnt[d]++;
      end
      for (int d = 0; d < 4; d++) begin
        tests++;
        if (cnt[d] != int'(levels[li]) + 1) begin
          failures++;
          $display("FAIL bright_duty b=%0d d=%0d got %0d want %0d", levels[li], d, cnt[d], int'(levels[li]) + 1);
        end
      end
    end
  endtask

  task automatic test_lz_suppress();
    logic [12:0] want;
    int cnt[4];
    logic [7:0] seg0, seg1;
    hex_in = {5'h00, 5'h00, 5'h05, 5'h00}; en_in = 4'hF; dp_in = '0; brightness = 4'd15;
    lz_suppress = 1'b1; load = 1'b1;
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 2) lz_suppress = 1'b0;
      for (int d = 0; d < 4; d++) cnt[d] = 0;
      seg0 = 8'h00; seg1 = 8'h00;
      do begin
        exp_q.push_back(expect_out(edges));
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({frame_start, an, sseg} !== want) begin
          failures++;
          $display("FAIL lz e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
        end
        for (int d = 0; d < 4; d++) if (an === ~(4'b0001 << d)) cnt[d]++;
        if (an === 4'b1110) seg0 = sseg;
        if (an === 4'b1101) seg1 = sseg;
      end while (edges % 64 != 0);
      if (pass > 0) begin
        for (int d = 0; d < 4; d++) begin
          tests++;
          if (cnt[d] != ((pass == 1 && d > 1) ? 0 : 16)) begin
            failures++;
            $display("FAIL lz_count pass=%0d d=%0d got %0d want %0d", pass, d, cnt[d], (pass == 1 && d > 1) ? 0 : 16);
          end
        end
        tests++;
        if (seg1 !== 8'b1_0100100 || seg0 !== 8'b1_0000001) begin
          failures++;
          $display("FAIL lz_glyph got d1=%h d0=%h want a4 81", seg1, seg0);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [12:0] want;
    int c1, c0, f;
    hex_in = {5'd4, 5'd3, 5'd2, 5'd1}; blink_in = 4'b0010; en_in = 4'hF; load = 1'b1;
    do begin
      exp_q.push_back(expect_out(edges));
      tick();
      want = exp_q.pop_front();
      tests++;
      if ({frame_start, an, sseg} !== want) begin
        failures++;
        $display("FAIL blink e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
      end
    end while (edges % 64 != 0);
    repeat (4) begin
      f = edges / 64;
      c1 = 0; c0 = 0;
      repeat (64) begin
        exp_q.push_back(expect_out(edges));
        tick();
        want = exp_q.pop_front();
        tests++;
        if ({frame_start, an, sseg} !== want) begin
          failures++;
          $display("FAIL blink e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
        end
        if (an === 4'b1101) c1++;
        if (an === 4'b1110) c0++;
      end
      tests++;
      if (c1 != ((((f / 2) % 2) == 1) ? 0 : 16) || c0 != 16) begin
        failures++;
        $display("FAIL blink_frame f=%0d got d1=%0d d0=%0d", f, c1, c0);
      end
    end
    blink_in = '0;
  endtask

  task automatic test_glyphs();
    en_in = 4'b0001; dp_in = 4'b0001; brightness = 4'd15;
    for (int code = 0; code <= 32; code++) begin
      if (code == 32) en_in = 4'b0000;
      while (edges % 64 != 63) tick();
      hex_in = {15'd0, 5'(code)}; load = 1'b1;
      tick();
      tick();
      tests++;
      if (code < 32 && {an, sseg} !== {4'b1110, 1'b0, glyph_ref(5'(code))}) begin
        failures++;
        $display("FAIL glyph code=%0h got an/sseg=%h/%h want e/%h", code, an, sseg, {1'b0, glyph_ref(5'(code))});
      end else if (code == 32 && {an, sseg} !== {4'hF, 8'hFF}) begin
        failures++;
        $display("FAIL glyph_dis got an/sseg=%h/%h want f/ff", an, sseg);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [12:0] want;
    hex_in = {5'd4, 5'd3, 5'd2, 5'd1}; en_in = 4'hF; dp_in = '0; load = 1'b1;
    do tick(); while (edges % 64 != 10);
    hex_in = {4{5'd7}}; dp_in = 4'hF; load = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    tests++;
    if ({frame_start, an, sseg} !== {1'b0, 4'hF, 8'hFF}) begin
      failures++;
      $display("FAIL async_reset got fs/an/sseg=%b/%h/%h want 0/f/ff", frame_start, an, sseg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    reset_model();
    repeat (130) begin
      exp_q.push_back(expect_out(edges));
      tick();
      want = exp_q.pop_front();
      tests++;
      if ({frame_start, an, sseg} !== want) begin
        failures++;
        $display("FAIL reset_discard e=%0d got fs/an/sseg=%b/%h/%h want %b/%h/%h", edges, frame_start, an, sseg, want[12], want[11:8], want[7:0]);
      end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_scan_order();
    test_tear_free();
    test_brightness();
    test_lz_suppress();
    test_blink();
    test_glyphs();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at edge %0d", edges);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sseg_scan_mux.md
# sseg_scan_mux

Parametrised time-multiplexed seven-segment driver for NUM_DIGITS common-anode digits. Accepts per-digit 5-bit glyph codes, decimal points, enables and blink flags. Adds tear-free frame-synchronous loading, brightness PWM, per-digit blinking and leading-zero suppression. Sits between the numeric formatting logic and the board's anode/segment pins.

## Interface
- NUM_DIGITS, 3: number of digits scanned (2..8)
- DWELL_BITS, 16: each digit is active for 2^DWELL_BITS clocks (≥4)
- BLINK_BITS, 8: blink phase toggles every 2^BLINK_BITS frames

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  capture strobe for all *_in buses
- hex_in  in  5*NUM_DIGITS  glyph code per digit; digit i = hex_in[5i+4:5i]
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- en_in  in  NUM_DIGITS  digit enable, 0 = blank
- blink_in  in  NUM_DIGITS  1 = digit blinks
- lz_suppress  in  1  leading-zero suppression enable (level, not latched)
- brightness  in  4  PWM duty, 0 = 1/16 … 15 = 16/16 (level, not latched)
- an  out  NUM_DIGITS  anode select, active-low, registered
- sseg  out  8  segments {dp,a,b,c,d,e,f,g}, active-low, registered
- frame_start  out  1  one-cycle pulse when a new scan of digit 0 begins

## Operation
- Active registers drive the display; pending registers plus pending flag hold loaded data.
- load=1 captures all *_in into pending and sets pending flag.
- Frame boundary: edge where dwell_cnt wraps and idx goes NUM_DIGITS-1 → 0. Pending is copied to active and the flag is cleared.
- load on the boundary edge: inputs go straight to active; flag cleared.
- No mid-frame change to active, so no tearing.
- dwell_cnt: DWELL_BITS-bit free-running counter.
- idx: increments on dwell_cnt wrap; wraps from NUM_DIGITS-1 to 0.
- blink_cnt: BLINK_BITS-bit counter, increments per frame boundary.
- blink_phase: toggles on blink_cnt wrap.
- Digit idx is lit when all of these hold:
  - en[idx]=1
  - not (blink[idx] and blink_phase)
  - not leading-zero-suppressed
  - dwell_cnt[DWELL_BITS-1:DWELL_BITS-4] ≤ brightness
- Lit: an = ~(1<<idx). Dark: an all ones and sseg = 8'hFF.
- Leading-zero suppression (lz_suppress=1): digit k>0 is blanked if its code and every higher digit's code are 5'h00. Digit 0 is never suppressed. A suppressed digit's dp is also dark.
- Glyphs, sseg[6:0] active-low, bit6 = a:
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111
  - 8:0000000, 9:0000100, A:0001000, b:1100000, C:0110001, d:1000010, E:0110000, F:0111000
  - 10h: U 1000001; 11h: dash 1111110; 12h: blank 1111111; 13h–1Fh: dash
- sseg[7] = ~dp[idx] when lit.

## Timing
- Reset (reset_n low, immediate):
  - dwell_cnt, idx, blink_cnt, blink_phase = 0
  - active and pending registers = 0; pending flag = 0
  - an = all ones, sseg = 8'hFF, frame_start = 0
- First lit output: the first clock after reset release, showing digit 0 with active values (all zero, so dark).
- an/sseg lag the counter state by exactly 1 clock (registered).
- frame_start is registered and asserts in the same cycle an first selects digit 0 of a new frame. Period = NUM_DIGITS·2^DWELL_BITS clocks.
- load-to-display latency: up to one frame; exactly 1 clock when load hits the boundary edge.
- reset_n asserted mid-frame or mid-load: all state cleared; pending data discarded.
- brightness and lz_suppress changes take effect on the next clock (not frame-synchronous).

## Test plan
- Reset and scan order. Params NUM_DIGITS=4, DWELL_BITS=4.
  - Hold reset_n=0 → an=4'hF, sseg=8'hFF.
  - Release; load hex 3,2,1,0, en=F, brightness=15 → an steps E,D,B,7 every 16 clocks after the first frame boundary.
  - frame_start pulses every 64 clocks.
- Tear-free load.
  - load mid-frame with new codes → no sseg change until the cycle frame_start=1; then the digit 0 glyph updates.
  - load exactly on the boundary edge → new value visible on the next clock.
- Brightness.
  - brightness=0 → each digit lit 1 of 16 dwell cycles (dwell_cnt top nibble = 0).
  - brightness=7 → lit 8 of 16.
  - brightness=15 → lit 16 of 16.
- Leading-zero suppression. Codes {0,0,5,0} (digit3..digit0), lz_suppress=1:
  - digits 3 and 2 dark;
  - digit 1 shows 0100100;
  - digit 0 shows 0000001.
  - lz_suppress=0 → all four lit.
- Blink. BLINK_BITS=1, blink_in=4'b0010 → digit 1 alternates lit/dark every 2 frames; other digits constant.
- Glyph coverage. Sweep codes 00h–1Fh on digit 0 with dp=1 → sseg matches the table with sseg[7]=0; en=0 → sseg=8'hFF.
